// File: rtl/tmc_uart_pkg.sv
// Shared types and helpers for the UART receive front-end.
package tmc_uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   localparam int DATA_BITS = 8;

   // Mid-bit offset used to centre the start-bit resample.
   function automatic int half_bit(input int clks_per_bit);
      return clks_per_bit / 2;
   endfunction

endpackage

// File: rtl/tmc_sync_fifo.sv
// Single-clock FIFO with a registered first-word-fall-through head, occupancy
// count and an overflow pulse for pushes that find the FIFO full.
module tmc_sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic [AW:0]      count,
   output logic             overflow
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_next;
   logic [AW:0]      count_next;
   logic [WIDTH-1:0] head_next;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign do_pop   = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push  = push & (~full | do_pop);
   assign overflow = push & full & ~do_pop;
   assign rd_next  = rd_ptr + AW'(do_pop);

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      count_next = count;
      if (do_push && !do_pop) begin
         count_next = count + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
         count_next = count - (AW+1)'(1);
      end
   end

   always_comb begin
      head_next = mem[rd_next];
      if (count_next == '0) begin
         head_next = '0;
      end else if (do_push && (wr_ptr == rd_next)) begin
         head_next = wr_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         head   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         rd_ptr <= rd_next;
         count  <= count_next;
         empty  <= (count_next == '0);
         head   <= head_next;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers, count and registered head keep stale words invisible.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: rtl/tmc_uart_rx_fifo.sv
// 8N1 UART receiver feeding a FWFT byte FIFO, with a strobe-edge pop and
// sticky framing/overflow flags for polling firmware.
module tmc_uart_rx_fifo
   import tmc_uart_pkg::*;
#(
   parameter  int CLKS_PER_BIT = 434,
   parameter  int DEPTH        = 16,
   localparam int AW           = $clog2(DEPTH)
) (
   input  logic          clk_clk,
   input  logic          reset_reset,
   input  logic          uart_rxd,
   output logic [7:0]    rx_char,
   output logic          rx_fifo_empty,
   input  logic          rx_fifo_read,
   output logic [AW:0]   rx_count,
   output logic          rx_frame_err,
   output logic          rx_overflow,
   input  logic          err_clear
);

   localparam int            BW          = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] FULL_RELOAD = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] HALF_RELOAD = BW'(half_bit(CLKS_PER_BIT) - 1);

   logic [1:0]           rxd_pipe;
   logic                 rxd_sync;
   rx_state_t            state_q;
   rx_state_t            state_next;
   logic [BW-1:0]        baud_cnt;
   logic                 baud_done;
   logic [2:0]           bit_cnt;
   logic                 bit_last;
   logic [DATA_BITS-1:0] data_q;
   logic                 load_half;
   logic                 load_full;
   logic                 shift_en;
   logic                 push;
   logic                 frame_evt;
   logic                 read_q;
   logic                 pop_req;
   logic                 fifo_overflow;

   assign rxd_sync  = rxd_pipe[1];
   assign baud_done = (baud_cnt == '0);
   assign bit_last  = (bit_cnt == 3'(DATA_BITS - 1));
   assign pop_req   = rx_fifo_read & ~read_q;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         rxd_pipe <= 2'b11;
         read_q   <= 1'b1;
      end else begin
         rxd_pipe <= {rxd_pipe[0], uart_rxd};
         read_q   <= rx_fifo_read;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_next;
      end
   end

   always_comb begin
      state_next = state_q;
      case (state_q)
         IDLE:    if (!rxd_sync) state_next = START;
         START:   if (baud_done) state_next = rxd_sync ? IDLE : DATA;
         DATA:    if (baud_done && bit_last) state_next = STOP;
         STOP:    if (baud_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      load_half = 1'b0;
      load_full = 1'b0;
      shift_en  = 1'b0;
      push      = 1'b0;
      frame_evt = 1'b0;
      case (state_q)
         IDLE:  load_half = ~rxd_sync;
         START: load_full = baud_done & ~rxd_sync;
         DATA: begin
            shift_en  = baud_done;
            load_full = baud_done;
         end
         STOP: begin
            push      = baud_done & rxd_sync;
            frame_evt = baud_done & ~rxd_sync;
         end
         default: ;
      endcase
   end

   // Baud counter free-runs down to zero and holds; each state entry reloads it.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         data_q   <= '0;
      end else begin
         if (load_half) begin
            baud_cnt <= HALF_RELOAD;
         end else if (load_full) begin
            baud_cnt <= FULL_RELOAD;
         end else if (!baud_done) begin
            baud_cnt <= baud_cnt - BW'(1);
         end
         if (state_q != DATA) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (shift_en) begin
            data_q <= {rxd_sync, data_q[DATA_BITS-1:1]};
         end
      end
   end

   // A new error event outranks a coincident clear.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         rx_frame_err <= 1'b0;
         rx_overflow  <= 1'b0;
      end else begin
         if (frame_evt) begin
            rx_frame_err <= 1'b1;
         end else if (err_clear) begin
            rx_frame_err <= 1'b0;
         end
         if (fifo_overflow) begin
            rx_overflow <= 1'b1;
         end else if (err_clear) begin
            rx_overflow <= 1'b0;
         end
      end
   end

   tmc_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk_clk),
      .rst      (reset_reset),
      .push     (push),
      .wr_data  (data_q),
      .pop      (pop_req),
      .head     (rx_char),
      .empty    (rx_fifo_empty),
      .count    (rx_count),
      .overflow (fifo_overflow)
   );

endmodule

// File: tb/tb_tmc_uart_rx_fifo.sv
// Scoreboard bench for tmc_uart_rx_fifo: directed UART frames, a draining
// monitor that checks each head byte against the expected queue.
module tb_tmc_uart_rx_fifo;

   localparam int CPB   = 16;
   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

   logic          clk_clk = 1'b0;
   logic          reset_reset;
   logic          uart_rxd;
   logic          err_clear;
   logic          tb_read;
   logic          mon_read;
   logic          rx_fifo_read;
   logic [7:0]    rx_char;
   logic          rx_fifo_empty;
   logic [AW:0]   rx_count;
   logic          rx_frame_err;
   logic          rx_overflow;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [7:0]    exp_q[$];
   bit            drain_en = 1'b0;
   int            hold_len = 0;

   assign rx_fifo_read = tb_read | mon_read;

   always #5 clk_clk = ~clk_clk;

   tmc_uart_rx_fifo #(
      .CLKS_PER_BIT (CPB),
      .DEPTH        (DEPTH)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset   (reset_reset),
      .uart_rxd      (uart_rxd),
      .rx_char       (rx_char),
      .rx_fifo_empty (rx_fifo_empty),
      .rx_fifo_read  (rx_fifo_read),
      .rx_count      (rx_count),
      .rx_frame_err  (rx_frame_err),
      .rx_overflow   (rx_overflow),
      .err_clear     (err_clear)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop);
      uart_rxd = 1'b0;
      repeat (CPB) @(negedge clk_clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = data[i];
         repeat (CPB) @(negedge clk_clk);
      end
      uart_rxd = stop;
      repeat (CPB) @(negedge clk_clk);
      uart_rxd = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] data);
      send_frame(data, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_clk);
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      @(negedge clk_clk);
      err_clear = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || !rx_fifo_empty || mon_read) && t < 4000) begin
         @(negedge clk_clk);
         t++;
      end
      if (t >= 4000) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got %0d bytes pending, want 0", name, exp_q.size());
      end
      check({name, "_count_after_drain"}, 32'(rx_count), 32'd0);
   endtask

   // Monitor: pops the head whenever draining is enabled and checks it in order.
   initial begin : monitor
      int         hold_cnt;
      logic [7:0] want;
      mon_read = 1'b0;
      hold_cnt = 0;
      forever begin
         @(negedge clk_clk);
         if (mon_read) begin
            if (hold_cnt == 0) mon_read = 1'b0;
            else hold_cnt--;
         end else if (drain_en && !rx_fifo_empty) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_unexpected: got 0x%0h, want no byte", rx_char);
            end else begin
               want = exp_q.pop_front();
               check("sb_head", 32'(rx_char), 32'(want));
            end
            mon_read = 1'b1;
            hold_cnt = hold_len;
         end
      end
   end

   initial begin : watchdog
      repeat (60000) @(posedge clk_clk);
      $display("FAIL watchdog: got no finish, want finish within 60000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      reset_reset = 1'b1;
      uart_rxd    = 1'b1;
      err_clear   = 1'b0;
      tb_read     = 1'b0;
      idle(3);
      reset_reset = 1'b0;
      idle(1);
      check("rst_char",  32'(rx_char),       32'h00);
      check("rst_empty", 32'(rx_fifo_empty), 32'd1);
      check("rst_count", 32'(rx_count),      32'd0);
      check("rst_ferr",  32'(rx_frame_err),  32'd0);
      check("rst_ovf",   32'(rx_overflow),   32'd0);

      // Single byte with exact push latency, then a manual pop.
      fork
         send_byte(8'hA5);
         begin
            idle(154);
            check("t1_empty_before_stop", 32'(rx_fifo_empty), 32'd1);
            idle(1);
            check("t1_empty_after_stop", 32'(rx_fifo_empty), 32'd0);
            check("t1_char",  32'(rx_char),  32'hA5);
            check("t1_count", 32'(rx_count), 32'd1);
         end
      join
      tb_read = 1'b1;
      idle(1);
      check("t1_pop_empty", 32'(rx_fifo_empty), 32'd1);
      check("t1_pop_char",  32'(rx_char),       32'h00);
      tb_read = 1'b0;
      idle(2);

      // Back-to-back frames, drained with a strobe held high for several cycles.
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h3C);
      idle(4);
      check("t2_count", 32'(rx_count), 32'd3);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h3C);
      hold_len = 3;
      drain_en = 1'b1;
      wait_drain("t2");
      drain_en = 1'b0;

      // Overflow: 17 bytes into 16 entries.
      for (int i = 1; i <= DEPTH + 1; i++) send_byte(8'(i));
      idle(4);
      check("t3_count", 32'(rx_count),    32'd16);
      check("t3_ovf",   32'(rx_overflow), 32'd1);
      check("t3_head",  32'(rx_char),     32'h01);
      for (int i = 1; i <= DEPTH; i++) exp_q.push_back(8'(i));
      hold_len = 0;
      drain_en = 1'b1;
      wait_drain("t3");
      drain_en = 1'b0;
      check("t3_ovf_sticky", 32'(rx_overflow), 32'd1);
      pulse_clear();
      check("t3_ovf_cleared", 32'(rx_overflow), 32'd0);

      // Framing error, then a clean frame.
      send_frame(8'h55, 1'b0);
      idle(32);
      check("t4_ferr",  32'(rx_frame_err),  32'd1);
      check("t4_empty", 32'(rx_fifo_empty), 32'd1);
      check("t4_count", 32'(rx_count),      32'd0);
      exp_q.push_back(8'h66);
      drain_en = 1'b1;
      send_byte(8'h66);
      wait_drain("t4");
      drain_en = 1'b0;
      check("t4_ferr_sticky", 32'(rx_frame_err), 32'd1);
      pulse_clear();
      check("t4_ferr_cleared", 32'(rx_frame_err), 32'd0);

      // Short low glitch is rejected; receiver still takes the next frame.
      uart_rxd = 1'b0;
      idle(CPB / 4);
      uart_rxd = 1'b1;
      idle(40);
      check("t5_empty", 32'(rx_fifo_empty), 32'd1);
      check("t5_ferr",  32'(rx_frame_err),  32'd0);
      check("t5_ovf",   32'(rx_overflow),   32'd0);
      exp_q.push_back(8'h5A);
      drain_en = 1'b1;
      send_byte(8'h5A);
      wait_drain("t5");
      drain_en = 1'b0;

      // Reset mid-DATA with bytes queued, strobe held high through reset.
      send_byte(8'h11);
      send_byte(8'h22);
      idle(2);
      check("t6_count_before_rst", 32'(rx_count), 32'd2);
      uart_rxd = 1'b0;
      idle(CPB);
      uart_rxd = 1'b1;
      idle(CPB);
      uart_rxd = 1'b0;
      idle(CPB);
      tb_read     = 1'b1;
      reset_reset = 1'b1;
      idle(1);
      uart_rxd = 1'b1;
      idle(2);
      reset_reset = 1'b0;
      idle(1);
      check("t6_rst_empty", 32'(rx_fifo_empty), 32'd1);
      check("t6_rst_count", 32'(rx_count),      32'd0);
      check("t6_rst_char",  32'(rx_char),       32'h00);
      send_byte(8'h42);
      idle(CPB * 2);
      check("t6_held_count", 32'(rx_count), 32'd1);
      check("t6_held_char",  32'(rx_char),  32'h42);
      tb_read = 1'b0;
      idle(1);
      exp_q.push_back(8'h42);
      drain_en = 1'b1;
      wait_drain("t6");
      drain_en = 1'b0;

      // Full FIFO: pop edge coincides with the push of a 17th byte.
      for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h80 + i));
      idle(2);
      check("t6_full_count", 32'(rx_count), 32'd16);
      fork
         send_byte(8'h90);
         begin
            idle(154);
            tb_read = 1'b1;
            idle(1);
            check("t6_coinc_count", 32'(rx_count),    32'd16);
            check("t6_coinc_ovf",   32'(rx_overflow), 32'd0);
            check("t6_coinc_head",  32'(rx_char),     32'h81);
            tb_read = 1'b0;
         end
      join
      idle(2);
      for (int i = 1; i <= DEPTH; i++) exp_q.push_back(8'(8'h80 + i));
      drain_en = 1'b1;
      wait_drain("t6_full");
      drain_en = 1'b0;
      check("t6_final_ovf", 32'(rx_overflow), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tmc_uart_rx_fifo.md
Name: tmc_uart_rx_fifo

Overview:
Serial receive front-end that directly feeds the Nios II soft-processor's receive-character PIO inputs.
- Deserialises 8N1 UART on the host link and buffers received bytes in a first-word-fall-through FIFO.
- Presents the head byte plus an empty flag to software, and pops one byte per rising edge of the software-driven read strobe.
- Flags framing errors and overflow with sticky bits for the firmware polling loop.

Parameters:
CLKS_PER_BIT, 434, clk_clk cycles per UART bit (50 MHz / 115200); must be >= 8
DEPTH, 16, FIFO entries; power of 2, >= 2
AW, $clog2(DEPTH), derived pointer width; not overridden

Ports:
clk_clk  in  1  system clock; all logic single clock domain
reset_reset  in  1  synchronous, active-high reset
uart_rxd  in  1  asynchronous serial input, idle high
rx_char  out  8  FIFO head byte; 8'h00 when empty
rx_fifo_empty  out  1  1 = no byte available
rx_fifo_read  in  1  level from PIO; each 0->1 transition pops one byte
rx_count  out  AW+1  current FIFO occupancy, 0..DEPTH
rx_frame_err  out  1  sticky: stop bit sampled low
rx_overflow  out  1  sticky: byte arrived while FIFO full
err_clear  in  1  single-cycle pulse clears both sticky flags

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: rx_char=8'h00, rx_fifo_empty=1, rx_count=0, rx_frame_err=0, rx_overflow=0.
  - Reset flushes the FIFO and aborts any in-flight frame; the FSM returns to IDLE.
  - The rxd synchroniser resets to 1.
  - The read-edge history register resets to 1, so a strobe held high through reset does not pop.
- Input synchronisation: uart_rxd passes through a 2-flop synchroniser; the FSM uses only the synchronised value.
- FSM states:
  - IDLE -> START on synchronised rxd == 0.
  - START: count CLKS_PER_BIT/2 cycles, then resample. If 0, go to DATA. If 1, treat as a glitch and return to IDLE with no error.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, shifted into the data register.
  - STOP: sample after CLKS_PER_BIT cycles (mid-stop). If 1, raise a push. If 0, set rx_frame_err and discard the byte. Either way, go to IDLE in the same cycle so back-to-back frames are caught.
- Bit counter: 3 bits. Baud counter: width $clog2(CLKS_PER_BIT), reloaded on each state entry.
- Pop detection: pop_req = rx_fifo_read & ~rx_fifo_read_q. The _q register updates every cycle.
- FIFO rules:
  - Push while not full: write at wr_ptr, increment wr_ptr and count.
  - Push while full: byte dropped, rx_overflow set, FIFO unchanged.
  - Exception: push and pop in the same cycle while full both succeed, count stays DEPTH, and no overflow is flagged.
  - Pop while empty: ignored, no error.
  - Push and pop in the same cycle while empty: push only; rx_count becomes 1.
  - Pointers wrap modulo DEPTH naturally (AW bits).
- Output timing: rx_char, rx_fifo_empty and rx_count are registered.
  - A push at cycle N is visible at N+1.
  - A pop edge sampled at N shows the next head (or empty, with rx_char=0) at N+1.
- Sticky flags: an error event coinciding with err_clear wins, so the flag stays 1.
- Latency from the mid-stop-bit sample to rx_fifo_empty=0 is 1 cycle.

Decomposition:
- Package tmc_uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP}
  - constant DATA_BITS=8
  - function for the half-bit count
- Sub-module tmc_sync_fifo (parameters WIDTH, DEPTH):
  - registered FWFT head
  - count output
  - full/empty
  - same-cycle push/pop-when-full rule
- Top level contains the synchroniser, FSM, edge detector and sticky flags.

Test Plan:
1. Send 0xA5 at CLKS_PER_BIT=16 -> rx_fifo_empty falls 1 cycle after the mid-stop sample; rx_char=0xA5; rx_count=1. Toggle rx_fifo_read 0->1 -> next cycle rx_fifo_empty=1, rx_char=0x00.
2. Send 0x00, 0xFF, 0x3C back to back (no idle gap) -> three pops in order return 0x00, 0xFF, 0x3C. Holding rx_fifo_read high between edges pops only once per edge.
3. Send DEPTH+1 bytes 0x01..0x11 with DEPTH=16 -> rx_count=16, rx_overflow=1, the 17th byte is lost, and 16 pops return 0x01..0x10. Then err_clear -> rx_overflow=0.
4. Frame 0x55 with the stop bit forced low -> rx_frame_err=1, rx_fifo_empty stays 1. A valid 0x66 follows and is received correctly.
5. Low glitch of CLKS_PER_BIT/4 cycles on rxd -> no byte, no error, FSM back in IDLE.
6. Each of these sequences:
   - Reset asserted mid-DATA with 2 bytes queued -> FIFO is empty.
   - rx_fifo_read held high through reset -> no pop occurs.
   - A following frame 0x42 -> received correctly.
   - FIFO full while a pop edge coincides with a push -> rx_count=16, rx_overflow=0.
